aes_block_packer: RTL and testbench

AES_BLOCK_PACKER -- requirements
Module: aes_block_packer

---
 rtl/aes_top_pack.sv | 15 +
 rtl/aes_block_packer.sv | 123 ++++++++++++
 tb/tb_aes_block_packer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_top_pack.sv
// Shared constants and types for the AES datapath top level.
package aes_top_pack;

  localparam int unsigned REG_SIZE          = 32;
  localparam int unsigned WORD_COUNTER_SIZE = 8;
  localparam int unsigned WORDS_PER_BLK     = 4;
  localparam int unsigned BLK_W             = REG_SIZE * WORDS_PER_BLK;

  // Packer message state: no message open, or a message being packed.
  typedef enum logic [0:0] {
    StIdle,
    StPack
  } pack_state_e;

endpackage

// File: rtl/aes_block_packer.sv
// Packs a framed word stream into AES-sized blocks with a one-deep output register.
module aes_block_packer
  import aes_top_pack::*;
#(
  parameter int unsigned WORD_W        = aes_top_pack::REG_SIZE,
  parameter int unsigned WORDS_PER_BLK = aes_top_pack::WORDS_PER_BLK,
  localparam int unsigned OUT_W        = WORD_W * WORDS_PER_BLK,
  localparam int unsigned IDX_W        = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WORD_W-1:0]            in_data,
  input  logic                         in_valid,
  input  logic                         in_sop,
  input  logic                         in_eop,
  output logic                         in_ready,
  output logic [OUT_W-1:0]             out_block,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [2:0]                   out_nwords,
  output logic [WORD_COUNTER_SIZE-1:0] blk_cnt,
  output logic                         proto_err
);

  pack_state_e                  state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [OUT_W-1:0]             acc_q, acc_d;
  logic [OUT_W-1:0]             out_block_q, out_block_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic [2:0]                   out_nwords_q, out_nwords_d;
  logic [WORD_COUNTER_SIZE-1:0] blk_cnt_q, blk_cnt_d;
  logic                         perr_q, perr_d;

  logic             accept;
  logic [IDX_W-1:0] widx;
  logic [OUT_W-1:0] merged;

  // The output register can take a new block whenever it is empty or being drained.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next-state: word placement, block completion, output hand-off and framing errors.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    out_block_d  = out_block_q;
    out_last_d   = out_last_q;
    out_nwords_d = out_nwords_q;
    perr_d       = 1'b0;
    out_valid_d  = out_valid_q && !out_ready;
    blk_cnt_d    = blk_cnt_q;
    if (out_valid_q && out_ready) begin
      blk_cnt_d = blk_cnt_q + 1'b1;
    end

    // A sop word always restarts at position 0 on a clean (zeroed) block.
    widx   = in_sop ? '0 : idx_q;
    merged = in_sop ? '0 : acc_q;
    for (int unsigned i = 0; i < WORDS_PER_BLK; i++) begin
      if (widx == IDX_W'(i)) begin
        merged[OUT_W-1-i*WORD_W -: WORD_W] = in_data;
      end
    end

    if (accept) begin
      if (state_q == StIdle && !in_sop) begin
        // Orphan word outside any message: dropped.
        perr_d = 1'b1;
      end else begin
        perr_d = (state_q == StPack) && in_sop;
        if (widx == IDX_W'(WORDS_PER_BLK - 1) || in_eop) begin
          out_block_d  = merged;
          out_valid_d  = 1'b1;
          out_last_d   = in_eop;
          out_nwords_d = 3'(widx) + 3'd1;
          acc_d        = '0;
          idx_d        = '0;
          state_d      = in_eop ? StIdle : StPack;
        end else begin
          acc_d   = merged;
          idx_d   = widx + 1'b1;
          state_d = StPack;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      acc_q        <= '0;
      out_block_q  <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_nwords_q <= '0;
      blk_cnt_q    <= '0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      out_block_q  <= out_block_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_nwords_q <= out_nwords_d;
      blk_cnt_q    <= blk_cnt_d;
      perr_q       <= perr_d;
    end
  end

  assign out_block  = out_block_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_nwords = out_nwords_q;
  assign blk_cnt    = blk_cnt_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer: vector table plus scoreboarded corner sequences.
module tb_aes_block_packer;
  import aes_top_pack::*;

  logic                         clk;
  logic                         rst_n;
  logic [31:0]                  in_data;
  logic                         in_valid, in_sop, in_eop, in_ready;
  logic [127:0]                 out_block;
  logic                         out_valid, out_ready, out_last;
  logic [2:0]                   out_nwords;
  logic [WORD_COUNTER_SIZE-1:0] blk_cnt;
  logic                         proto_err;

  aes_block_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_ready   (in_ready),
    .out_block  (out_block),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_nwords (out_nwords),
    .blk_cnt    (blk_cnt),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] blk;
    logic         last;
    logic [2:0]   nw;
  } exp_t;

  typedef struct {
    logic [31:0]  data;
    logic         sop;
    logic         eop;
    logic         err;
    logic         emit;
    logic [127:0] blk;
    logic         last;
    logic [2:0]   nw;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  int nchecks = 0;
  int nerr    = 0;
  int perr_seen = 0;
  int exp_perr  = 0;
  logic [WORD_COUNTER_SIZE-1:0] exp_cnt = '0;
  logic         hold_pend = 1'b0;
  logic [127:0] hold_blk;
  logic         hold_last;
  logic [2:0]   hold_nw;
  logic         ir_low_seen = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] blk4(input logic [31:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  function automatic vec_t mk(input logic [31:0] d, input logic s, e, err, emit,
                              input logic [127:0] b, input logic l, input logic [2:0] n);
    vec_t v;
    v.data = d; v.sop = s; v.eop = e; v.err = err; v.emit = emit;
    v.blk = b; v.last = l; v.nw = n;
    return v;
  endfunction

  task automatic push(input logic [127:0] b, input logic l, input logic [2:0] n);
    exp_t e;
    e.blk = b; e.last = l; e.nw = n;
    sb.push_back(e);
  endtask

  // Offers one word and returns at posedge+1 after it has been accepted.
  task automatic send(input logic [31:0] d, input logic s, input logic e);
    int n = 0;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      nchecks++; nerr++;
      $display("FAIL send_timeout: in_ready stuck at 0 for word %h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_block", out_block, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_nwords", out_nwords, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = '0; hold_pend = 1'b0;
    sb.delete();
  endtask

  // Output monitor: scoreboard pops, hold stability, handshake rule and counter tracking.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      chk("blk_cnt", blk_cnt, exp_cnt);
      if (proto_err) perr_seen++;
      if (!in_ready) ir_low_seen = 1'b1;
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_block", out_block, hold_blk);
        chk("hold_last", out_last, hold_last);
        chk("hold_nwords", out_nwords, hold_nw);
      end
      hold_pend = out_valid && !out_ready;
      hold_blk = out_block; hold_last = out_last; hold_nw = out_nwords;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          nchecks++; nerr++;
          $display("FAIL unexpected_block: got %h expected none", out_block);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_block", out_block, e.blk);
          chk("out_last", out_last, e.last);
          chk("out_nwords", out_nwords, e.nw);
        end
        exp_cnt = exp_cnt + 1'b1;
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    out_ready = 1'b1;

    // Reset state
    #2;
    chk("por_out_valid", out_valid, 0);
    chk("por_in_ready", in_ready, 1);
    chk("por_blk_cnt", blk_cnt, 0);
    @(posedge clk); #1;
    pulse_reset();

    // 8-word message
    tbl.push_back(mk(32'h1, 1, 0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(32'h2, 0, 0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(32'h3, 0, 0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(32'h4, 0, 0, 0, 1, blk4(32'h1, 32'h2, 32'h3, 32'h4), 0, 4));
    tbl.push_back(mk(32'h5, 0, 0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(32'h6, 0, 0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(32'h7, 0, 0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(32'h8, 0, 1, 0, 1, blk4(32'h5, 32'h6, 32'h7, 32'h8), 1, 4));
    // 6-word message, short last block
    tbl.push_back(mk(32'h11, 1, 0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(32'h12, 0, 0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(32'h13, 0, 0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(32'h14, 0, 0, 0, 1, blk4(32'h11, 32'h12, 32'h13, 32'h14), 0, 4));
    tbl.push_back(mk(32'h15, 0, 0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(32'h16, 0, 1, 0, 1, blk4(32'h15, 32'h16, 32'h0, 32'h0), 1, 2));
    // single-word message
    tbl.push_back(mk(32'haa, 1, 1, 0, 1, blk4(32'haa, 32'h0, 32'h0, 32'h0), 1, 1));
    // orphan word, then restart mid-message
    tbl.push_back(mk(32'hbad, 0, 0, 1, 0, '0, 0, 0));
    tbl.push_back(mk(32'h21, 1, 0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(32'h22, 0, 0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(32'h31, 1, 0, 1, 0, '0, 0, 0));
    tbl.push_back(mk(32'h32, 0, 0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(32'h33, 0, 1, 0, 1, blk4(32'h31, 32'h32, 32'h33, 32'h0), 1, 3));

    perr_seen = 0;
    foreach (tbl[i]) begin
      send(tbl[i].data, tbl[i].sop, tbl[i].eop);
      if (tbl[i].emit) push(tbl[i].blk, tbl[i].last, tbl[i].nw);
      if (tbl[i].err) exp_perr++;
    end
    idle(4);
    chk("table_drained", sb.size(), 0);
    chk("table_proto_err", perr_seen, exp_perr);
    chk("table_blk_cnt", blk_cnt, 6);

    // Backpressure: 12-word message with out_ready low for 10 cycles
    ir_low_seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send(32'h100 + i, i == 0, i == 11);
          if (i % 4 == 3) push(blk4(32'h100 + i - 3, 32'h100 + i - 2, 32'h100 + i - 1,
                                     32'h100 + i), i == 11, 4);
        end
      end
      begin
        idle(2);
        out_ready = 1'b0;
        idle(10);
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("bp_drained", sb.size(), 0);
    chk("bp_in_ready_fell", ir_low_seen, 1);
    chk("bp_blk_cnt", blk_cnt, 9);

    // Reset mid-message discards the partial block
    send(32'h41, 1, 0);
    send(32'h42, 0, 0);
    pulse_reset();
    for (int i = 0; i < 4; i++) send(32'h51 + i, i == 0, i == 3);
    push(blk4(32'h51, 32'h52, 32'h53, 32'h54), 1, 4);
    idle(4);
    chk("mr_drained", sb.size(), 0);
    chk("mr_blk_cnt", blk_cnt, 1);

    // Counter wrap: 2^N + 1 blocks
    pulse_reset();
    for (int i = 0; i < (1 << WORD_COUNTER_SIZE) + 1; i++) begin
      send(32'(i), 1, 1);
      push(blk4(32'(i), 32'h0, 32'h0, 32'h0), 1, 1);
    end
    idle(4);
    chk("wrap_drained", sb.size(), 0);
    chk("wrap_blk_cnt", blk_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
